// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state codes, lamp encodings and default timing for the traffic controller
package traffic_pkg;

    // FSM state codes; 101..111 are illegal and trigger recovery
    localparam logic [2:0] S_NS_GREEN  = 3'b000;
    localparam logic [2:0] S_NS_YELLOW = 3'b001;
    localparam logic [2:0] S_ALL_RED   = 3'b010;
    localparam logic [2:0] S_EW_GREEN  = 3'b011;
    localparam logic [2:0] S_EW_YELLOW = 3'b100;

    // One-hot lamp encodings {red, yellow, green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Default dwell lengths in clock cycles
    localparam int DEF_GREEN_TICKS  = 10;
    localparam int DEF_YELLOW_TICKS = 3;
    localparam int DEF_RED_TICKS    = 2;

    // Lamp pair as seen by both roads
    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamp_pair_t;

    // True for the five legal state codes
    function automatic logic state_is_legal(input logic [2:0] st);
        return (st <= S_EW_YELLOW);
    endfunction

endpackage

// File: rtl/improved_basic_traffic_light_if.sv
// rtl/improved_basic_traffic_light_if.sv - observation bundle carrying lamps and internal FSM registers
interface improved_basic_traffic_light_if;

    logic [2:0] NS_light;
    logic [2:0] EW_light;
    logic [3:0] clk_count;
    logic [2:0] state;
    logic [2:0] prev_state;

    // Controller side drives everything
    modport master (
        output NS_light,
        output EW_light,
        output clk_count,
        output state,
        output prev_state
    );

    // Observer side (monitor, bench, display logic)
    modport slave (
        input NS_light,
        input EW_light,
        input clk_count,
        input state,
        input prev_state
    );

endinterface

// File: rtl/traffic_lamp_decode.sv
// rtl/traffic_lamp_decode.sv - combinational map from FSM state code to both road lamps
module traffic_lamp_decode
    import traffic_pkg::*;
(
    input  logic [2:0] state,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light
);

    // Decode state to lamps; anything unrecognised shows red on both roads
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state)
            S_NS_GREEN:  ns_light = LAMP_GREEN;
            S_NS_YELLOW: ns_light = LAMP_YELLOW;
            S_EW_GREEN:  ew_light = LAMP_GREEN;
            S_EW_YELLOW: ew_light = LAMP_YELLOW;
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

endmodule

// File: rtl/improved_basic_traffic_light.sv
// rtl/improved_basic_traffic_light.sv - fixed-time two-road traffic light FSM with all-red clearance
module improved_basic_traffic_light
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
    parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
    parameter int RED_TICKS    = DEF_RED_TICKS
) (
    input  logic                            clk,
    input  logic                            rst,
    improved_basic_traffic_light_if.master  lights
);

    // Last count value of each state; ticks are limited to 1..16 so D-1 fits in 4 bits
    localparam logic [3:0] GREEN_LAST  = 4'(GREEN_TICKS - 1);
    localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_TICKS - 1);
    localparam logic [3:0] RED_LAST    = 4'(RED_TICKS - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] prev_state_q, prev_state_d;
    logic [3:0] clk_count_q, clk_count_d;
    logic [3:0] dwell_last;
    logic [2:0] next_state;
    logic [2:0] ns_light, ew_light;

    // Pick the final count value for the state currently held
    always_comb begin
        dwell_last = RED_LAST;
        case (state_q)
            S_NS_GREEN, S_EW_GREEN:   dwell_last = GREEN_LAST;
            S_NS_YELLOW, S_EW_YELLOW: dwell_last = YELLOW_LAST;
            default:                  dwell_last = RED_LAST;
        endcase
    end

    // Successor state; all-red hands green to the road that did not just have it
    always_comb begin
        next_state = S_ALL_RED;
        case (state_q)
            S_NS_GREEN:  next_state = S_NS_YELLOW;
            S_NS_YELLOW: next_state = S_ALL_RED;
            S_EW_GREEN:  next_state = S_EW_YELLOW;
            S_EW_YELLOW: next_state = S_ALL_RED;
            S_ALL_RED:   next_state = (prev_state_q == S_NS_YELLOW) ? S_EW_GREEN : S_NS_GREEN;
            default:     next_state = S_ALL_RED;
        endcase
    end

    // Dwell counting and transitions; an illegal code falls back to the reset condition
    always_comb begin
        state_d      = state_q;
        prev_state_d = prev_state_q;
        clk_count_d  = clk_count_q;
        if (!state_is_legal(state_q)) begin
            state_d      = S_ALL_RED;
            prev_state_d = S_EW_YELLOW;
            clk_count_d  = 4'd0;
        end else if (clk_count_q != dwell_last) begin
            clk_count_d  = clk_count_q + 4'd1;
        end else begin
            clk_count_d  = 4'd0;
            prev_state_d = state_q;
            state_d      = next_state;
        end
    end

    // State registers; reset parks in all-red as if EW yellow had just ended so NS goes first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ALL_RED;
            prev_state_q <= S_EW_YELLOW;
            clk_count_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            prev_state_q <= prev_state_d;
            clk_count_q  <= clk_count_d;
        end
    end

    traffic_lamp_decode u_lamp_decode (
        .state    (state_q),
        .ns_light (ns_light),
        .ew_light (ew_light)
    );

    assign lights.NS_light   = ns_light;
    assign lights.EW_light   = ew_light;
    assign lights.clk_count  = clk_count_q;
    assign lights.state      = state_q;
    assign lights.prev_state = prev_state_q;

endmodule

// File: tb/tb_improved_basic_traffic_light.sv
// tb/tb_improved_basic_traffic_light.sv - table-driven scoreboard bench for the traffic light controller
module tb_improved_basic_traffic_light;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    improved_basic_traffic_light_if lights ();

    improved_basic_traffic_light dut (
        .clk    (clk),
        .rst    (rst),
        .lights (lights)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] st;
        logic [2:0] pv;
        logic [3:0] cnt;
        logic [2:0] ns;
        logic [2:0] ew;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic [2:0] pv;
        int         dwell;
        logic [2:0] ns;
        logic [2:0] ew;
    } seg_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    seg_t segs[6];

    function automatic logic [15:0] pack_obs();
        return {lights.state, lights.prev_state, lights.clk_count, lights.NS_light, lights.EW_light};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_safety(input string name);
        logic ok;
        ok = !((lights.NS_light != 3'b100) && (lights.EW_light != 3'b100))
             && ($countones(lights.NS_light) == 1) && ($countones(lights.EW_light) == 1);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual ns=%b ew=%b required both one-hot and at least one red",
                     name, lights.NS_light, lights.EW_light);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        vec_t e;
        logic [2:0] last_st;
        logic [2:0] last_pv;
        logic       found;

        // NS green, NS yellow, all-red, EW green, EW yellow, all-red
        segs[0] = '{3'b000, 3'b010, 10, 3'b001, 3'b100};
        segs[1] = '{3'b001, 3'b000,  3, 3'b010, 3'b100};
        segs[2] = '{3'b010, 3'b001,  2, 3'b100, 3'b100};
        segs[3] = '{3'b011, 3'b010, 10, 3'b100, 3'b001};
        segs[4] = '{3'b100, 3'b011,  3, 3'b100, 3'b010};
        segs[5] = '{3'b010, 3'b100,  2, 3'b100, 3'b100};

        vecs.push_back('{1'b1, 3'b010, 3'b100, 4'd0, 3'b100, 3'b100});
        vecs.push_back('{1'b0, 3'b010, 3'b100, 4'd1, 3'b100, 3'b100});
        for (int rep = 0; rep < 2; rep++)
            for (int s = 0; s < 6; s++)
                for (int c = 0; c < segs[s].dwell; c++)
                    vecs.push_back('{1'b0, segs[s].st, segs[s].pv, 4'(c), segs[s].ns, segs[s].ew});
        vecs.push_back('{1'b0, 3'b000, 3'b010, 4'd0, 3'b001, 3'b100});

        @(negedge clk);
        last_st = 3'b010;
        last_pv = 3'b100;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst = v.rst;
            exp_q.push_back(v);
            step();
            e = exp_q.pop_front();
            check($sformatf("vec%0d", i), pack_obs(), {e.st, e.pv, e.cnt, e.ns, e.ew});
            check_safety($sformatf("safety%0d", i));
            if (last_st == 3'b010 && lights.state != 3'b010 && i > 1)
                check($sformatf("alternate%0d", i), {13'd0, lights.state},
                      {13'd0, (last_pv == 3'b001) ? 3'b011 : 3'b000});
            last_st = lights.state;
            last_pv = lights.prev_state;
        end

        // Mid-operation reset at EW green, count 5
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (lights.state == 3'b011 && lights.clk_count == 4'd5) found = 1'b1;
            else step();
        end
        check("reach_ew_green_5", {15'd0, found}, 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_reset", pack_obs(), {3'b010, 3'b100, 4'd0, 3'b100, 3'b100});
        step();
        check("mid_reset_c1", pack_obs(), {3'b010, 3'b100, 4'd1, 3'b100, 3'b100});
        step();
        check("mid_reset_ns", pack_obs(), {3'b000, 3'b010, 4'd0, 3'b001, 3'b100});
        for (int k = 0; k < 4; k++) begin
            step();
            check_safety($sformatf("safety_post_reset%0d", k));
        end

        // Illegal state recovery
        force dut.state_q = 3'b111;
        #1;
        check("illegal_lamps", {10'd0, lights.NS_light, lights.EW_light}, {10'd0, 3'b100, 3'b100});
        release dut.state_q;
        step();
        check("illegal_recover", pack_obs(), {3'b010, 3'b100, 4'd0, 3'b100, 3'b100});
        step();
        step();
        check("illegal_then_ns", pack_obs(), {3'b000, 3'b010, 4'd0, 3'b001, 3'b100});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
